// File: rtl/initialization_command_word_sequencer_if.sv
// initialization_command_word_sequencer_if: write bus from the read/write logic into the ICW sequencer
interface initialization_command_word_sequencer_if;
  logic write_strobe;
  logic address_0;
  logic [7:0] internal_data_bus;
  modport master (output write_strobe, address_0, internal_data_bus);
  modport slave (input write_strobe, address_0, internal_data_bus);
endinterface

// File: rtl/initialization_command_word_sequencer.sv
// initialization_command_word_sequencer: sequences ICW1..ICW4 into config registers, then routes OCW writes as strobes
module initialization_command_word_sequencer #(
  parameter int CASCADE_CHANNELS = 8,
  parameter logic [4:0] RESET_VECTOR_BASE = 5'h00
) (
  input  logic clock,
  input  logic reset_n,
  initialization_command_word_sequencer_if.slave bus,
  output logic [2:0] interrupt_vector_address,
  output logic level_or_edge_triggered_config,
  output logic call_address_interval_4_or_8_config,
  output logic single_or_cascade_config,
  output logic set_icw4_config,
  output logic [4:0] interrupt_vector_base,
  output logic [CASCADE_CHANNELS-1:0] cascade_device_config,
  output logic microprocessor_mode_config,
  output logic auto_eoi_config,
  output logic buffered_master_or_slave_config,
  output logic buffered_mode_config,
  output logic special_fully_nested_config,
  output logic initialization_restart,
  output logic initialization_done,
  output logic operation_command_word_1_strobe,
  output logic operation_command_word_2_or_3_strobe
);
  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
  state_t state, state_next;
  logic [7:0] d;
  logic icw1, wr_a1, ld_icw2, ld_icw3, ld_icw4, ocw1, ocw23;
  always_comb begin
    d = bus.internal_data_bus;
    icw1 = bus.write_strobe && !bus.address_0 && d[4];
    wr_a1 = bus.write_strobe && bus.address_0;
    ld_icw2 = wr_a1 && state == WAIT_ICW2;
    ld_icw3 = wr_a1 && state == WAIT_ICW3;
    ld_icw4 = wr_a1 && state == WAIT_ICW4;
    ocw1 = wr_a1 && state == READY;
    ocw23 = bus.write_strobe && !bus.address_0 && !d[4] && state == READY;
    // single/ICW4 flags were captured by ICW1 and steer which words are still owed
    state_next = icw1 ? WAIT_ICW2 :
                 ld_icw2 ? (!single_or_cascade_config ? WAIT_ICW3 : set_icw4_config ? WAIT_ICW4 : READY) :
                 ld_icw3 ? (set_icw4_config ? WAIT_ICW4 : READY) :
                 ld_icw4 ? READY : state;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      interrupt_vector_address <= '0;
      level_or_edge_triggered_config <= 1'b0;
      call_address_interval_4_or_8_config <= 1'b0;
      single_or_cascade_config <= 1'b0;
      set_icw4_config <= 1'b0;
      interrupt_vector_base <= RESET_VECTOR_BASE;
      cascade_device_config <= '0;
      {special_fully_nested_config, buffered_mode_config, buffered_master_or_slave_config,
       auto_eoi_config, microprocessor_mode_config} <= '0;
      initialization_restart <= 1'b0;
      initialization_done <= 1'b0;
      operation_command_word_1_strobe <= 1'b0;
      operation_command_word_2_or_3_strobe <= 1'b0;
    end else begin
      state <= state_next;
      initialization_restart <= icw1;
      initialization_done <= state_next == READY;
      operation_command_word_1_strobe <= ocw1;
      operation_command_word_2_or_3_strobe <= ocw23;
      if (icw1) begin
        interrupt_vector_address <= d[7:5];
        level_or_edge_triggered_config <= d[3];
        call_address_interval_4_or_8_config <= d[2];
        single_or_cascade_config <= d[1];
        set_icw4_config <= d[0];
        cascade_device_config <= '0;
        {special_fully_nested_config, buffered_mode_config, buffered_master_or_slave_config,
         auto_eoi_config, microprocessor_mode_config} <= '0;
      end
      if (ld_icw2) interrupt_vector_base <= d[7:3];
      if (ld_icw3) cascade_device_config <= d[CASCADE_CHANNELS-1:0];
      if (ld_icw4)
        {special_fully_nested_config, buffered_mode_config, buffered_master_or_slave_config,
         auto_eoi_config, microprocessor_mode_config} <= d[4:0];
    end
  end
endmodule

// File: tb/tb_initialization_command_word_sequencer.sv
// tb_initialization_command_word_sequencer: directed plus random writes checked against a word-queue reference model
module tb_initialization_command_word_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] interrupt_vector_address;
  logic level_or_edge_triggered_config, call_address_interval_4_or_8_config;
  logic single_or_cascade_config, set_icw4_config;
  logic [4:0] interrupt_vector_base;
  logic [7:0] cascade_device_config;
  logic microprocessor_mode_config, auto_eoi_config, buffered_master_or_slave_config;
  logic buffered_mode_config, special_fully_nested_config;
  logic initialization_restart, initialization_done;
  logic operation_command_word_1_strobe, operation_command_word_2_or_3_strobe;
  int n_cmp = 0;
  int n_err = 0;
  initialization_command_word_sequencer_if bus();
  initialization_command_word_sequencer #(.CASCADE_CHANNELS(8), .RESET_VECTOR_BASE(5'h00)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .interrupt_vector_address(interrupt_vector_address),
    .level_or_edge_triggered_config(level_or_edge_triggered_config),
    .call_address_interval_4_or_8_config(call_address_interval_4_or_8_config),
    .single_or_cascade_config(single_or_cascade_config),
    .set_icw4_config(set_icw4_config),
    .interrupt_vector_base(interrupt_vector_base),
    .cascade_device_config(cascade_device_config),
    .microprocessor_mode_config(microprocessor_mode_config),
    .auto_eoi_config(auto_eoi_config),
    .buffered_master_or_slave_config(buffered_master_or_slave_config),
    .buffered_mode_config(buffered_mode_config),
    .special_fully_nested_config(special_fully_nested_config),
    .initialization_restart(initialization_restart),
    .initialization_done(initialization_done),
    .operation_command_word_1_strobe(operation_command_word_1_strobe),
    .operation_command_word_2_or_3_strobe(operation_command_word_2_or_3_strobe)
  );
  always #5 clock = ~clock;
  // Model: ICW1 fields, plus a queue of the ICW numbers still owed before the device is ready
  logic [6:0] m_icw1;
  logic [4:0] m_base;
  logic [7:0] m_cas;
  logic [4:0] m_icw4;
  bit m_inited, m_restart, m_ocw1, m_ocw23;
  int pending[$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic void model_reset();
    m_icw1 = '0; m_base = 5'h00; m_cas = '0; m_icw4 = '0;
    m_inited = 0; m_restart = 0; m_ocw1 = 0; m_ocw23 = 0;
    pending.delete();
  endfunction
  function automatic void model_write(input logic ws, input logic a0, input logic [7:0] d);
    m_restart = 0; m_ocw1 = 0; m_ocw23 = 0;
    if (!ws) return;
    if (!a0 && d[4]) begin
      m_icw1 = {d[7:5], d[3:0]};
      m_cas = '0; m_icw4 = '0;
      pending.delete();
      pending.push_back(2);
      if (!d[1]) pending.push_back(3);
      if (d[0]) pending.push_back(4);
      m_inited = 1; m_restart = 1;
    end else if (m_inited && pending.size() > 0) begin
      if (a0) begin
        if (pending[0] == 2) m_base = d[7:3];
        else if (pending[0] == 3) m_cas = d;
        else m_icw4 = d[4:0];
        void'(pending.pop_front());
      end
    end else if (m_inited) begin
      if (a0) m_ocw1 = 1; else m_ocw23 = 1;
    end
  endfunction
  task automatic compare_all();
    check("icw1_fields", {interrupt_vector_address, level_or_edge_triggered_config,
          call_address_interval_4_or_8_config, single_or_cascade_config, set_icw4_config}, m_icw1);
    check("vector_base", interrupt_vector_base, m_base);
    check("cascade", cascade_device_config, m_cas);
    check("icw4_fields", {special_fully_nested_config, buffered_mode_config, buffered_master_or_slave_config,
          auto_eoi_config, microprocessor_mode_config}, m_icw4);
    check("done", initialization_done, m_inited && pending.size() == 0);
    check("restart", initialization_restart, m_restart);
    check("ocw1", operation_command_word_1_strobe, m_ocw1);
    check("ocw23", operation_command_word_2_or_3_strobe, m_ocw23);
  endtask
  task automatic step(input logic ws, input logic a0, input logic [7:0] d);
    bus.write_strobe = ws; bus.address_0 = a0; bus.internal_data_bus = d;
    model_write(ws, a0, d);
    @(posedge clock); #1;
    compare_all();
    @(negedge clock);
  endtask
  task automatic wr(input logic a0, input logic [7:0] d);
    step(1'b1, a0, d);
  endtask
  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial begin
    bus.write_strobe = 1'b0; bus.address_0 = 1'b0; bus.internal_data_bus = 8'h00;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);
    wr(1'b1, 8'h55);
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h48);
    check("single_wait_icw4", initialization_done, 1'b0);
    wr(1'b1, 8'h03);
    check("single_done", initialization_done, 1'b1);
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h04);
    check("casc_not_done", initialization_done, 1'b0);
    wr(1'b1, 8'h01);
    check("casc_cascade_val", cascade_device_config, 8'h04);
    check("casc_base_val", interrupt_vector_base, 5'h04);
    wr(1'b0, 8'h1B);
    check("reinit_ltim", level_or_edge_triggered_config, 1'b1);
    wr(1'b1, 8'h08);
    wr(1'b1, 8'h00);
    wr(1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    wr(1'b0, 8'h20);
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h08);
    wr(1'b0, 8'h05);
    wr(1'b1, 8'h02);
    pulse_reset();
    wr(1'b1, 8'h55);
    wr(1'b0, 8'h05);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
